// File: rtl/cordic_seq.sv
// Iterative CORDIC engine: two chained micro-rotations per clock over 10 RUN
// cycles, driving the shared arctangent ROM stage index and pulsing done.
module cordic_seq #(
    parameter int W = 27
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] z_in,
    output logic [4:0]          stage,
    input  logic signed [W-1:0] atan0,
    input  logic signed [W-1:0] atan1,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] z_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic                mode_q, busy_q, done_q;
    logic signed [W-1:0] x_q, y_q, z_q;

    logic [4:0]          sh0, sh1;
    logic                d0, d1;
    logic signed [W-1:0] x_m, y_m, z_m;
    logic signed [W-1:0] x_d, y_d, z_d;

    assign sh0 = (state_q == RUN) ? {cnt_q, 1'b0} : 5'd0;
    assign sh1 = sh0 + 5'd1;

    // d=1 means rotate by +atan: rotation chases z to 0, vectoring chases y to 0
    assign d0  = mode_q ? y_q[W-1] : ~z_q[W-1];
    assign x_m = d0 ? x_q - (y_q >>> sh0) : x_q + (y_q >>> sh0);
    assign y_m = d0 ? y_q + (x_q >>> sh0) : y_q - (x_q >>> sh0);
    assign z_m = d0 ? z_q - atan0         : z_q + atan0;

    assign d1  = mode_q ? y_m[W-1] : ~z_m[W-1];
    assign x_d = d1 ? x_m - (y_m >>> sh1) : x_m + (y_m >>> sh1);
    assign y_d = d1 ? y_m + (x_m >>> sh1) : y_m - (x_m >>> sh1);
    assign z_d = d1 ? z_m - atan1         : z_m + atan1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        mode_q  <= mode;
                        x_q     <= x_in;
                        y_q     <= y_in;
                        z_q     <= z_in;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (cnt_q == 4'd9) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stage = sh0;
    assign busy  = busy_q;
    assign done  = done_q;
    assign x_out = x_q;
    assign y_out = y_q;
    assign z_out = z_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Scoreboard bench for cordic_seq: a 20-iteration CORDIC reference model feeds
// an expectation queue; a negedge monitor checks results, latency and stage.
module tb_cordic_seq;
    localparam int W = 27;
    localparam logic signed [W-1:0] KINV = 27'sh4DBA77;

    typedef struct {
        logic signed [W-1:0] x, y, z;
        int                  cyc;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
    logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic [4:0] stage;
    logic signed [W-1:0] atan0, atan1, x_out, y_out, z_out;
    logic busy, done;

    logic signed [W-1:0] rom [0:31];
    exp_t q[$];
    int   cyc = 0;
    int   total = 0, bad = 0;
    int   run_idx = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign atan0 = rom[stage];
    assign atan1 = rom[5'(stage + 5'd1)];

    cordic_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .stage(stage), .atan0(atan0), .atan1(atan1),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cyc %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic near(input string nm, input longint act, input longint exp, input longint tol);
        longint diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        total++;
        if (diff > tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    // Plain 20-step CORDIC over the same ROM contents the DUT is fed
    function automatic exp_t model(input bit m, input logic signed [W-1:0] x, y, z);
        logic signed [W-1:0] xs, ys, zs, xn, yn;
        exp_t e;
        xs = x; ys = y; zs = z;
        for (int i = 0; i < 20; i++) begin
            if (m ? (ys < 0) : (zs >= 0)) begin
                xn = xs - (ys >>> i); yn = ys + (xs >>> i); zs = zs - rom[i];
            end else begin
                xn = xs + (ys >>> i); yn = ys - (xs >>> i); zs = zs + rom[i];
            end
            xs = xn; ys = yn;
        end
        e.x = xs; e.y = ys; e.z = zs; e.cyc = 0;
        return e;
    endfunction

    // Called at a negedge: drive operands with start high and queue the expectation
    task automatic drive(input bit m, input logic signed [W-1:0] x, y, z, input int done_cyc);
        exp_t e;
        mode = m; x_in = x; y_in = y; z_in = z; start = 1'b1;
        e = model(m, x, y, z);
        e.cyc = done_cyc;
        q.push_back(e);
    endtask

    task automatic do_op(input bit m, input logic signed [W-1:0] x, y, z);
        drive(m, x, y, z, cyc + 11);
        @(negedge clk) start = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    task automatic b2b(input bit m1, input logic signed [W-1:0] x1, y1, z1,
                       input bit m2, input logic signed [W-1:0] x2, y2, z2);
        int c0;
        c0 = cyc;
        drive(m1, x1, y1, z1, c0 + 11);
        @(negedge clk);
        drive(m2, x2, y2, z2, c0 + 22);
        repeat (11) @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    function automatic logic signed [W-1:0] rnd(input int r);
        return W'(int'($urandom_range(0, 2 * r)) - r);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            run_idx = 0;
        end else begin
            total++;
            if (busy && done) begin
                bad++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
            end
            if (busy) begin
                chk("stage_run", stage, 2 * run_idx);
                run_idx++;
            end else begin
                chk("stage_idle", stage, 0);
            end
            if (done) begin
                chk("busy_len", run_idx, 10);
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_done: got done with empty queue, expected none");
                end else begin
                    exp_t e;
                    total--;
                    e = q.pop_front();
                    chk("x_out", x_out, e.x);
                    chk("y_out", y_out, e.y);
                    chk("z_out", z_out, e.z);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            if (!busy) run_idx = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        real p;
        exp_t e;
        bit found;
        p = 1.0;
        for (int i = 0; i < 32; i++) begin
            rom[i] = (i < 20) ? W'($rtoi($atan(p) * 8388608.0 + 0.5)) : '0;
            p = p / 2.0;
        end

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stage", stage, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_z", z_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // rotation by pi/4 with K-prescaled x
        do_op(1'b0, KINV, 27'sd0, 27'sh6487ED);
        near("rot45_x", x_out, 27'sh5A8279, 64);
        near("rot45_y", y_out, 27'sh5A8279, 64);
        near("rot45_z", z_out, 0, 64);

        do_op(1'b1, 27'sh400000, 27'sh400000, 27'sd0);
        near("vec_z", z_out, 27'sh6487ED, 64);
        near("vec_x", x_out, 27'sh950C4A, 64);
        near("vec_y", y_out, 0, 64);
        e = model(1'b1, 27'sh400000, 27'sh400000, 27'sd0);
        repeat (3) @(negedge clk);
        chk("hold_x", x_out, e.x);
        chk("hold_z", z_out, e.z);

        // start pulse during RUN must be ignored
        drive(1'b0, 27'sh300000, -27'sh200000, 27'sh100000, cyc + 11);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        mode = 1'b1; x_in = 27'sh700000; y_in = 27'sh123456; z_in = -27'sh400000;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);

        b2b(1'b0, 27'sh500000, 27'sh100000, -27'sh800000,
            1'b1, 27'sh900000, -27'sh600000, 27'sh050000);

        // reset in the middle of a run
        mode = 1'b0; x_in = 27'sh200000; y_in = 27'sh200000; z_in = 27'sh300000;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (stage == 5'd8) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_stage8", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_stage", stage, 0);
        chk("arst_x", x_out, 0);
        chk("arst_y", y_out, 0);
        chk("arst_z", z_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(1'b0, KINV, 27'sd0, 27'sd0);
        near("post_rst_x", x_out, 27'sh800000, 64);
        near("post_rst_y", y_out, 0, 64);

        for (int n = 0; n < 40; n++) begin
            bit m;
            logic signed [W-1:0] rx, ry, rz;
            m  = 1'($urandom_range(0, 1));
            ry = rnd(27'sh1000000);
            rz = rnd(27'shD00000);
            rx = m ? W'($urandom_range(1, 27'sh1000000)) : rnd(27'sh1000000);
            if (n % 8 == 7)
                b2b(m, rx, ry, rz, 1'b0, rnd(27'sh1000000), rnd(27'sh1000000), rnd(27'shD00000));
            else
                do_op(m, rx, ry, rz);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cordic_seq.md
# cordic_seq

Iterative CORDIC engine and sequencer built around the shared two-entry-per-stage arctangent ROM. On a start request it latches x/y/z operands and a mode. It then steps the ROM stage index through 0, 2, …, 18 and performs two micro-rotations per clock, 20 iterations in 10 cycles. It returns the rotated or vectored result with a one-cycle done pulse. It sits between the peripheral register interface and the arctangent ROM; the ROM is instantiated externally and wired to `stage` / `atan0` / `atan1`.

## Interface
- `W`, 27: datapath width. Signed two's-complement; angles and coordinates are Q3.23 (π/4 = 0x6487ED).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin operation; sampled every edge, acted on only when not RUN.
- `mode` in 1: 0 = rotation (drive z→0), 1 = vectoring (drive y→0); latched on accepted start.
- `x_in`, `y_in`, `z_in` in W: operands, latched on accepted start.
- `stage` out 5: ROM stage index; ROM output is consumed combinationally in the same cycle.
- `atan0`, `atan1` in W: ROM angles for iteration `stage` and `stage+1`.
- `busy` out 1: high in every RUN cycle.
- `done` out 1: one-cycle pulse, results valid.
- `x_out`, `y_out`, `z_out` out W: working registers.

## Operation
- FSM states:
  - IDLE: waiting for a start.
  - RUN: iterating.
  - DONE: result cycle.
- Transitions:
  - IDLE/DONE → RUN on `start`: load x, y, z from the inputs, latch `mode`, clear `cnt`.
  - RUN, `cnt` < 9 → RUN, `cnt`+1.
  - RUN, `cnt` = 9 → DONE.
  - DONE → IDLE if no `start`.
- `stage` = 2·`cnt` in RUN; 0 in IDLE/DONE.
- Each RUN cycle runs two chained micro-rotations, i = `stage` then i = `stage`+1, using `atan0` and then `atan1`:
  - direction d = +1 if (rotation: z ≥ 0) / (vectoring: y < 0), else −1;
  - x' = x − d·(y >>> i);
  - y' = y + d·(x >>> i);
  - z' = z − d·atan;
  - the second step uses the first step's results, including a recomputed d.
- Arithmetic:
  - arithmetic right shift;
  - W-bit wraparound, no saturation, no rounding;
  - no gain compensation; the output magnitude carries K⁻¹ ≈ 1.646760;
  - ROM angle values are used exactly as supplied, including zero entries.
- Valid operand range (caller responsibility):
  - |x_in|, |y_in| ≤ 0x1800000;
  - rotation-mode |z_in| ≤ 1.74 rad;
  - vectoring mode requires x_in > 0.
- `start` while RUN is ignored: no restart, no queueing.
- `start` in the DONE cycle is accepted; back-to-back operations are allowed.
- Results remain stable after DONE until the next accepted start.

## Timing
- Reset, async on `rst_n` low, and held while low:
  - state = IDLE;
  - `cnt` = 0, `stage` = 0;
  - `busy` = 0, `done` = 0;
  - x/y/z registers = 0;
  - mode = 0.
- Reset mid-RUN aborts immediately, with no done pulse. The first start after release runs a full clean operation.
- `start` sampled high at edge T (from IDLE):
  - RUN during cycles T+1 … T+10, with `stage` = 0, 2, …, 18;
  - `busy` = 1 in those cycles;
  - registers update at the end of each RUN cycle;
  - DONE cycle T+11: `done` = 1, `busy` = 0, results valid.
- Latency start→done is 11 cycles; throughput is 11 cycles per operation.
- `busy` and `done` are never high together.
- `x_out`/`y_out`/`z_out` change only on accepted start and at RUN edges.

## Test plan
- Rotation, π/4: mode=0, x_in=0x4DBA77 (K), y_in=0, z_in=0x6487ED → at done, x_out ≈ y_out ≈ 0x5A8279 ±64 LSB, |z_out| ≤ 64 LSB, done exactly 11 cycles after start.
- Vectoring: mode=1, x_in=0x400000, y_in=0x400000, z_in=0 → z_out ≈ 0x6487ED ±64, x_out ≈ 0x950C4A ±64, |y_out| ≤ 64.
- Stage sequence: one run → `stage` = 0, 2, 4, …, 18 on consecutive busy cycles, 0 otherwise; busy high exactly 10 cycles.
- Start while busy: second start pulse at RUN cycle 4 with different operands → ignored; results match the first operation; single done pulse.
- Back-to-back: start held high through done → second operation accepted in the DONE cycle; second done 11 cycles after the first.
- Reset mid-run: rst_n low during `stage`=8 → busy=0, done=0, stage=0, outputs 0 asynchronously; after release, a rotation with z_in=0 and x_in=0x4DBA77 yields x_out ≈ 0x800000 ±64, y_out ≈ 0 ±64.
